// File: rtl/ikbd_pkg.sv
// Shared types and helpers for the IKBD keyboard-matrix scanner.
package ikbd_pkg;

    localparam int unsigned IKBD_BREAK_BIT = 7;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        COMPARE,
        NEXT
    } scan_state_t;

    typedef struct packed {
        logic       brk;
        logic [6:0] idx;
    } ikbd_event_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ikbd_evt_fifo.sv
// Synchronous first-word-fall-through event FIFO, 8 bits wide, with occupancy output.
module ikbd_evt_fifo
    import ikbd_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [7:0]            data_i,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [7:0]            data_o,
    output logic [clog2(DEPTH):0] level_o
);
    localparam int unsigned AW = clog2(DEPTH);
    localparam logic [AW:0] LVL_PRE_FULL = (AW + 1)'(DEPTH - 1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   level_q;
    logic          full_q;
    logic          do_push;
    logic          do_pop;

    // Push is gated by the registered full flag, so a same-cycle pop never frees a slot early.
    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && (level_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10: begin
                    level_q <= level_q + (AW + 1)'(1);
                    full_q  <= (level_q == LVL_PRE_FULL);
                end
                2'b01: begin
                    level_q <= level_q - (AW + 1)'(1);
                    full_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign full_o  = full_q;
    assign empty_o = (level_q == '0);
    assign data_o  = mem_q[rd_q];
    assign level_o = level_q;

endmodule

// File: rtl/ikbd_matrix_scan.sv
// Keyboard-matrix scanner: drives columns one-cold, debounces each key and
// queues IKBD make/break codes into an event FIFO.
module ikbd_matrix_scan
    import ikbd_pkg::*;
#(
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 15,
    parameter int unsigned SETTLE     = 3,
    parameter int unsigned DEBOUNCE   = 3,
    parameter int unsigned SCAN_GAP   = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic                       en,
    output logic [COLS-1:0]            col_o,
    input  logic [ROWS-1:0]            row_i,
    output logic                       ev_valid,
    input  logic                       ev_ready,
    output logic [7:0]                 ev_code,
    output logic [clog2(FIFO_DEPTH):0] fifo_level,
    output logic                       busy
);
    localparam int unsigned KEYS = ROWS * COLS;
    localparam int unsigned CW   = (COLS > 1) ? clog2(COLS) : 1;
    localparam int unsigned RW   = (ROWS > 1) ? clog2(ROWS) : 1;
    localparam int unsigned SW   = clog2(SETTLE + 1);
    localparam int unsigned DW   = clog2(DEBOUNCE + 1);
    localparam int unsigned GW   = clog2(SCAN_GAP + 1);

    localparam logic [CW-1:0] COL_LAST    = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE - 1);
    localparam logic [GW-1:0] GAP_INIT    = GW'(SCAN_GAP);

    scan_state_t     state_q;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   row_q;
    logic [SW-1:0]   settle_q;
    logic [GW-1:0]   gap_q;
    logic [ROWS-1:0] snap_q;
    logic [ROWS-1:0] row_m_q;
    logic [ROWS-1:0] row_s_q;
    logic [KEYS-1:0] stable_q;
    logic [DW-1:0]   cnt_q [KEYS];
    logic [COLS-1:0] col_o_q;
    logic            busy_q;

    logic [CW-1:0]   col_d;
    logic [6:0]      key_idx;
    logic            key_now;
    logic            key_stable;
    logic            flip_due;
    logic            push;
    logic            fifo_full;
    logic            fifo_empty;
    ikbd_event_t     ev;

    assign col_d      = col_q + CW'(1);
    assign key_idx    = 7'(32'(col_q) * ROWS + 32'(row_q));
    assign key_now    = snap_q[row_q];
    assign key_stable = stable_q[key_idx];
    assign flip_due   = (key_now != key_stable) && (cnt_q[key_idx] >= DB_LAST);
    assign push       = (state_q == COMPARE) && flip_due && !fifo_full;

    always_comb begin
        ev     = '0;
        ev.brk = ~key_now;
        ev.idx = key_idx;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            settle_q <= '0;
            gap_q    <= '0;
            snap_q   <= '0;
            row_m_q  <= '1;
            row_s_q  <= '1;
            stable_q <= '0;
            for (int unsigned i = 0; i < KEYS; i++) cnt_q[i] <= '0;
            col_o_q  <= '1;
            busy_q   <= 1'b0;
        end else begin
            row_m_q <= row_i;
            row_s_q <= row_m_q;
            case (state_q)
                IDLE: begin
                    if (en && (gap_q == '0)) begin
                        col_q    <= '0;
                        settle_q <= '0;
                        col_o_q  <= ~COLS'(1);
                        busy_q   <= 1'b1;
                        state_q  <= DRIVE;
                    end else if (gap_q != '0) begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                DRIVE: begin
                    if (settle_q == SETTLE_LAST) state_q <= SAMPLE;
                    else settle_q <= settle_q + SW'(1);
                end
                SAMPLE: begin
                    snap_q  <= ~row_s_q;
                    row_q   <= '0;
                    state_q <= COMPARE;
                end
                COMPARE: begin
                    // A flip that cannot be queued freezes the whole scan until the FIFO drains.
                    if (!(flip_due && fifo_full)) begin
                        if (key_now == key_stable) begin
                            cnt_q[key_idx] <= '0;
                        end else if (flip_due) begin
                            stable_q[key_idx] <= key_now;
                            cnt_q[key_idx]    <= '0;
                        end else begin
                            cnt_q[key_idx] <= cnt_q[key_idx] + DW'(1);
                        end
                        if (row_q == ROW_LAST) begin
                            col_o_q <= '1;
                            state_q <= NEXT;
                        end else begin
                            row_q <= row_q + RW'(1);
                        end
                    end
                end
                NEXT: begin
                    if (col_q == COL_LAST) begin
                        gap_q   <= GAP_INIT;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        col_q    <= col_d;
                        settle_q <= '0;
                        col_o_q  <= ~(COLS'(1) << col_d);
                        state_q  <= DRIVE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    ikbd_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (res),
        .push_i (push),
        .data_i (ev),
        .pop_i  (ev_ready),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .data_o (ev_code),
        .level_o(fifo_level)
    );

    assign col_o    = col_o_q;
    assign busy     = busy_q;
    assign ev_valid = !fifo_empty;

endmodule
